// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with one-cycle done pulse at terminal count and optional auto-reload
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  // Load beats decrement; terminal count either reloads or parks at zero in EXPIRED
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        reload_reg <= load_value;
        count      <= load_value;
        state      <= (load_value != '0) ? RUN : IDLE;
      end else if (state == RUN && enable) begin
        if (count == WIDTH'(1)) begin
          done  <= 1'b1;
          count <= auto_reload ? reload_reg : '0;
          state <= auto_reload ? RUN : EXPIRED;
        end else if (count != '0)
          count <= count - WIDTH'(1);
      end
    end
  assign busy    = state == RUN;
  assign expired = state == EXPIRED;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed stimulus with a reference-model scoreboard plus fixed expected sequences
module tb_down_counter_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       auto_reload = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       expired;
  typedef struct packed {
    logic [3:0] c;
    logic       b;
    logic       d;
    logic       x;
  } exp_t;
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_done;
  logic [3:0] m_count;
  logic [3:0] m_reload;
  int         m_state;
  logic       m_done;
  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .load_value(load_value),
    .auto_reload(auto_reload),
    .count(count),
    .busy(busy),
    .done(done),
    .expired(expired)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_count  = '0;
    m_reload = '0;
    m_state  = 0;
    m_done   = 1'b0;
  endtask
  task automatic step(input logic en, input logic ld, input logic [3:0] lv, input logic ar);
    exp_t e;
    enable      = en;
    load        = ld;
    load_value  = lv;
    auto_reload = ar;
    m_done = 1'b0;
    if (ld) begin
      m_reload = lv;
      m_count  = lv;
      m_state  = (lv != 0) ? 1 : 0;
    end else if (m_state == 1 && en) begin
      if (m_count == 1) begin
        m_done = 1'b1;
        if (ar) m_count = m_reload;
        else begin
          m_count = 0;
          m_state = 2;
        end
      end else m_count = m_count - 4'd1;
    end
    q.push_back('{m_count, m_state == 1, m_done, m_state == 2});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_count", 32'(count), 32'(e.c));
    chk("sb_busy", 32'(busy), 32'(e.b));
    chk("sb_done", 32'(done), 32'(e.d));
    chk("sb_expired", 32'(expired), 32'(e.x));
    if (done) n_done++;
  endtask
  initial begin
    logic [3:0] seq4 [9];
    seq4 = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_expired", 32'(expired), 0);
    // single shot from 5
    step(0, 1, 5, 0);
    chk("t2_load_count", 32'(count), 5);
    chk("t2_load_busy", 32'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 0);
      chk("t2_count", 32'(count), 32'(5 - i));
      chk("t2_done", 32'(done), 32'(i == 5));
    end
    chk("t2_expired", 32'(expired), 1);
    chk("t2_busy", 32'(busy), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_hold_count", 32'(count), 0);
    chk("t2_hold_done", 32'(done), 0);
    chk("t2_hold_expired", 32'(expired), 1);
    // gated enable
    step(0, 1, 4, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step(i % 2 == 0, 0, 0, 0);
      chk("t3_count", 32'(count), 32'(4 - (i / 2) - 1 + ((i % 2 == 0) ? 0 : 0)));
      chk("t3_done", 32'(done), 32'(i == 6));
    end
    chk("t3_done_once", 32'(n_done), 1);
    chk("t3_expired", 32'(expired), 1);
    // periodic auto-reload
    step(0, 1, 3, 1);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 1);
      chk("t4_count", 32'(count), 32'(seq4[i]));
      chk("t4_done", 32'(done), 32'(i % 3 == 2));
      chk("t4_busy", 32'(busy), 1);
    end
    // load zero, then load at terminal edge
    step(0, 1, 0, 0);
    chk("t5_zero_busy", 32'(busy), 0);
    chk("t5_zero_expired", 32'(expired), 0);
    chk("t5_zero_done", 32'(done), 0);
    step(1, 0, 0, 0);
    chk("t5_idle_count", 32'(count), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    step(0, 1, 2, 0);
    step(1, 0, 0, 0);
    chk("t5_pre_term", 32'(count), 1);
    step(1, 1, 9, 0);
    chk("t5_term_load_count", 32'(count), 9);
    chk("t5_term_load_busy", 32'(busy), 1);
    chk("t5_term_load_done", 32'(done), 0);
    // reset mid-run at count 6
    step(0, 1, 8, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_pre_count", 32'(count), 6);
    reset = 1'b1;
    #2;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_expired", 32'(expired), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      chk("t6_idle_count", 32'(count), 0);
      chk("t6_idle_busy", 32'(busy), 0);
    end
    step(0, 1, 2, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_restart_done", 32'(done), 1);
    chk("t6_restart_expired", 32'(expired), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
